pc_sel_unit: RTL and testbench
==============================

Name: pc_sel_unit

Overview:
- Program-counter and next-PC stage directly downstream of the branch comparator.
- Consumes BrEq/BrLT/work plus funct3 and jump flags, and decides branch taken / not taken.
- Holds the PC register and presents fetch addresses to instruction fetch with a valid/ready handshake.
- On a redirect it issues a one-cycle flush and inserts one bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address width; only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- br_valid  in  1  control-flow instruction resolved this cycle; qualifies is_branch, is_jal, is_jalr, funct3, target.
- is_branch  in  1  B-type instruction.
- is_jal  in  1  JAL.
- is_jalr  in  1  JALR.
- funct3  in  3  funct3 of the B-type instruction.
- BrEq  in  1  comparator: A equals B.
- BrLT  in  1  comparator: A less than B.
- work  in  1  comparator active. Branch outcome is used only when work=1.
- target  in  32  redirect target address (PC+imm, or rs1+imm for JALR).
- fetch_ready  in  1  fetch accepts fetch_pc this cycle.
- fetch_valid  out  1  fetch_pc is valid.
- fetch_pc  out  32  current fetch address.
- taken  out  1  combinational: resolved instruction redirects.
- flush  out  1  registered one-cycle pulse on redirect; younger instructions are discarded.
- misalign_err  out  1  sticky: redirect target not 4-byte aligned.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_RESET, fetch_pc=RESET_PC.
  - fetch_valid=0, flush=0, misalign_err=0.
  - taken is combinational: 0 whenever br_valid=0.
- Branch decode, active when br_valid & is_branch & work:
  - 000 BEQ: BrEq.
  - 001 BNE: ~BrEq.
  - 100 BLT / 110 BLTU: BrLT.
  - 101 BGE / 111 BGEU: ~BrLT.
  - 010 / 011: not taken.
  - is_branch with work=0: not taken.
- taken = br_valid & (is_jal | is_jalr | branch_taken).
- Flag priority when several are set: is_jalr > is_jal > is_branch.
- Effective target: target & ~32'h1 for JALR, target unchanged otherwise.
- States:
  - S_RESET: fetch_valid=0. On the first clk edge after rst_n rises, go to S_RUN.
  - S_RUN: fetch_valid=1.
    - If taken and eff_target[1:0]==0: next fetch_pc=eff_target, flush=1 next cycle, go to S_REDIR.
    - If taken and eff_target[1]==1: go to S_HALT, misalign_err=1, fetch_pc holds.
    - Else if fetch_ready: fetch_pc += 4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
    - Else: fetch_pc holds.
    - Redirect wins over sequential advance in the same cycle, regardless of fetch_ready.
  - S_REDIR: fetch_valid=0 (one bubble), flush=1 this cycle only.
    - br_valid is ignored (the instruction is being flushed), and taken output is forced to 0.
    - Next state S_RUN with fetch_pc=eff_target.
  - S_HALT: fetch_valid=0, taken forced to 0, misalign_err=1. Stays until rst_n.
- Redirect latency: taken at edge N -> fetch_pc=target visible after edge N, fetch_valid=1 after edge N+1.
- Reset mid-operation (any state): asynchronous return to the reset values. A pending redirect is lost.
- fetch_pc is always 4-byte aligned.

Decomposition:
- Package pc_sel_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State enum S_RESET, S_RUN, S_REDIR, S_HALT.
  - INSN_BYTES=4.
- Sub-module branch_taken_dec: combinational funct3/BrEq/BrLT/work -> branch_taken.

Test Plan:
- Reset then 3 cycles with fetch_ready=1 -> fetch_pc 0x0, 0x4, 0x8, 0xC. fetch_valid=0 in the first cycle after reset release.
- fetch_ready=0 for 2 cycles at pc=0x10 -> fetch_pc holds 0x10, then 0x14 once fetch_ready=1.
- BEQ with BrEq=1, work=1, target=0x100 at pc=0x20 -> taken=1; flush=1 for one cycle with fetch_valid=0; then fetch_pc=0x100 with fetch_valid=1. BNE with BrEq=1 -> taken=0 and pc advances by 4.
- JALR target=0x203 -> eff 0x202 -> S_HALT, misalign_err=1, fetch_valid=0 until reset. JALR target=0x201 -> fetch_pc=0x200.
- is_branch=1, funct3=100, BrLT=1, work=0 -> taken=0. Also br_valid held high during S_REDIR is ignored, and no second flush occurs.
- RESET_PC=32'hFFFF_FFF8, two accepts -> 0xFFFF_FFFC then 0x0000_0000. Assert rst_n=0 mid-S_REDIR -> outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_sel_pkg.sv
// Shared constants and state encoding for the PC select / next-PC stage.
package pc_sel_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_REDIR,
    S_HALT
  } state_t;

endpackage

// File: rtl/pc_sel_unit_branch_taken_dec.sv
// B-type outcome from funct3 and comparator flags; signed/unsigned share the flags.
module branch_taken_dec
  import pc_sel_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       work,
  output logic       branch_taken
);

  always_comb begin
    branch_taken = 1'b0;
    if (work) begin
      case (funct3)
        F3_BEQ:           branch_taken = br_eq;
        F3_BNE:           branch_taken = ~br_eq;
        F3_BLT, F3_BLTU:  branch_taken = br_lt;
        F3_BGE, F3_BGEU:  branch_taken = ~br_lt;
        default:          branch_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pc_sel_unit.sv
// PC register and next-PC select: sequential advance, redirect with one bubble,
// and a sticky halt on a misaligned redirect target.
module pc_sel_unit
  import pc_sel_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic            BrEq,
  input  logic            BrLT,
  input  logic            work,
  input  logic [XLEN-1:0] target,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            taken,
  output logic            flush,
  output logic            misalign_err
);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] eff_target;
  logic            branch_taken;
  logic            flush_nx;
  logic            err_nx;

  branch_taken_dec u_dec (
    .funct3       (funct3),
    .br_eq        (BrEq),
    .br_lt        (BrLT),
    .work         (work),
    .branch_taken (branch_taken)
  );

  // JALR clears bit 0; jumps are taken regardless of the comparator.
  assign eff_target = is_jalr ? (target & ~XLEN'(1)) : target;
  assign taken      = br_valid & (is_jalr | is_jal | (is_branch & branch_taken))
                    & (state != S_REDIR) & (state != S_HALT);
  assign fetch_valid = (state == S_RUN);

  always_comb begin
    state_nx = state;
    pc_nx    = fetch_pc;
    flush_nx = 1'b0;
    err_nx   = misalign_err;
    case (state)
      S_RESET: state_nx = S_RUN;
      S_RUN: begin
        if (taken) begin
          if (eff_target[1:0] == 2'b00) begin
            pc_nx    = eff_target;
            flush_nx = 1'b1;
            state_nx = S_REDIR;
          end else begin
            err_nx   = 1'b1;
            state_nx = S_HALT;
          end
        end else if (fetch_ready) begin
          pc_nx = fetch_pc + XLEN'(INSN_BYTES);
        end
      end
      // Target already loaded on entry; this cycle is the bubble.
      S_REDIR: state_nx = S_RUN;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RESET;
      fetch_pc     <= RESET_PC;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nx;
      fetch_pc     <= pc_nx;
      flush        <= flush_nx;
      misalign_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_pc_sel_unit.sv
// Directed bench for pc_sel_unit: sequential fetch, stalls, redirects, halt, wrap, reset.
module tb_pc_sel_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        BrEq, BrLT, work;
  logic [31:0] target;
  logic        fetch_ready;
  logic        fetch_valid, taken, flush, misalign_err;
  logic [31:0] fetch_pc;
  logic        fetch_valid2, taken2, flush2, misalign_err2;
  logic [31:0] fetch_pc2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sel_unit dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .BrEq(BrEq),
    .BrLT(BrLT), .work(work), .target(target), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .taken(taken),
    .flush(flush), .misalign_err(misalign_err)
  );

  pc_sel_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .BrEq(BrEq),
    .BrLT(BrLT), .work(work), .target(target), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid2), .fetch_pc(fetch_pc2), .taken(taken2),
    .flush(flush2), .misalign_err(misalign_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; BrEq = 0; BrLT = 0; work = 0; target = 32'h0;
  endtask

  task automatic ctl(input logic br, input logic jalr, input logic jal,
                     input logic [2:0] f3, input logic eq, input logic lt,
                     input logic wk, input logic [31:0] tgt);
    br_valid = 1; is_branch = br; is_jalr = jalr; is_jal = jal;
    funct3 = f3; BrEq = eq; BrLT = lt; work = wk; target = tgt;
  endtask

  initial begin
    rst_n = 0; fetch_ready = 1; idle();
    #12;
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_err", misalign_err, 0);
    chk("rst_taken", taken, 0);
    chk("rst_pc_wrapinst", fetch_pc2, 32'hFFFF_FFF8);
    rst_n = 1; #1;
    chk("first_cycle_valid", fetch_valid, 0);

    step(); chk("run_pc0", fetch_pc, 32'h0); chk("run_valid", fetch_valid, 1);
    step(); chk("pc4", fetch_pc, 32'h4);
    step(); chk("pc8", fetch_pc, 32'h8);
    step(); chk("pcC", fetch_pc, 32'hC);
    step(); chk("pc10", fetch_pc, 32'h10);

    fetch_ready = 0;
    step(); chk("stall1", fetch_pc, 32'h10);
    step(); chk("stall2", fetch_pc, 32'h10);
    fetch_ready = 1;
    step(); chk("resume", fetch_pc, 32'h14);
    step(); step(); step();
    chk("pc20", fetch_pc, 32'h20);

    // BEQ taken, stall on fetch must not block the redirect
    fetch_ready = 0;
    ctl(1, 0, 0, 3'b000, 1, 0, 1, 32'h100); #1;
    chk("beq_taken", taken, 1);
    step();
    chk("redir_pc", fetch_pc, 32'h100);
    chk("redir_flush", flush, 1);
    chk("redir_valid", fetch_valid, 0);
    // a jump still presented during the bubble must be ignored
    ctl(0, 0, 1, 3'b000, 0, 0, 0, 32'h300); #1;
    chk("redir_taken_forced", taken, 0);
    step();
    chk("after_redir_pc", fetch_pc, 32'h100);
    chk("after_redir_valid", fetch_valid, 1);
    chk("no_second_flush", flush, 0);
    fetch_ready = 1;

    ctl(1, 0, 0, 3'b001, 1, 0, 1, 32'h400); #1;
    chk("bne_eq_not_taken", taken, 0);
    step(); chk("bne_advance", fetch_pc, 32'h104); chk("bne_flush", flush, 0);

    ctl(1, 0, 0, 3'b100, 0, 1, 0, 32'h400); #1;
    chk("blt_work0", taken, 0);
    work = 1; #1;     chk("blt_lt", taken, 1);
    funct3 = 3'b101; #1; chk("bge_lt", taken, 0);
    funct3 = 3'b111; BrLT = 0; #1; chk("bgeu_ge", taken, 1);
    funct3 = 3'b010; #1; chk("f3_010", taken, 0);
    idle(); #1;       chk("no_valid", taken, 0);
    step(); chk("pc108", fetch_pc, 32'h108);

    // JALR wins over a not-taken branch flag; bit 0 cleared
    ctl(1, 1, 0, 3'b010, 0, 0, 1, 32'h201); #1;
    chk("jalr_taken", taken, 1);
    step(); idle();
    chk("jalr_pc", fetch_pc, 32'h200); chk("jalr_flush", flush, 1);
    step(); chk("jalr_valid", fetch_valid, 1);
    step(); chk("pc204", fetch_pc, 32'h204);

    ctl(0, 1, 0, 3'b000, 0, 0, 0, 32'h203); #1;
    step();
    chk("halt_err", misalign_err, 1);
    chk("halt_valid", fetch_valid, 0);
    chk("halt_pc", fetch_pc, 32'h204);
    chk("halt_flush", flush, 0);
    ctl(0, 0, 1, 3'b000, 0, 0, 0, 32'h500); #1;
    chk("halt_taken_forced", taken, 0);
    step(); idle();
    chk("halt_sticky", misalign_err, 1);
    chk("halt_stays", fetch_valid, 0);

    rst_n = 0; #1;
    chk("rst2_err", misalign_err, 0);
    chk("rst2_pc", fetch_pc, 32'h0);
    rst_n = 1;
    step(); chk("wrap_start", fetch_pc2, 32'hFFFF_FFF8); chk("wrap_valid", fetch_valid2, 1);
    step(); chk("wrap_fffc", fetch_pc2, 32'hFFFF_FFFC);
    step(); chk("wrap_zero", fetch_pc2, 32'h0);
    chk("pc_before_redir", fetch_pc, 32'h8);

    ctl(1, 0, 0, 3'b000, 1, 0, 1, 32'h40); #1;
    step(); idle();
    chk("mid_redir_flush", flush, 1);
    rst_n = 0; #1;
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_pc", fetch_pc, 32'h0);
    chk("mid_rst_valid", fetch_valid, 0);
    rst_n = 1;
    step();
    chk("lost_redir_pc", fetch_pc, 32'h0);
    chk("lost_redir_valid", fetch_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
